// File: rtl/sgm_frame_sequencer.sv
// Frame-level control for the SGM disparity datapath: stream position tracking,
// path-beginning strobes, line-buffer addressing, penalty registers and sync delay.
module sgm_frame_sequencer #(
   parameter int HALF_IMG_WIDTH = 640,
   parameter int ROW_WIDTH      = 10,
   parameter int COL_WIDTH      = 11,
   parameter int PIPE_LATENCY   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 de_in,
   input  logic                 h_sync_in,
   input  logic                 v_sync_in,
   input  logic                 cfg_valid,
   input  logic [7:0]           cfg_p1,
   input  logic [7:0]           cfg_p2,
   output logic                 cfg_ready,
   output logic [7:0]           p1,
   output logic [7:0]           p2,
   output logic                 half_de,
   output logic                 ext_half_de,
   output logic                 beg_horizontal,
   output logic                 beg_top,
   output logic                 beg_diag_l2r,
   output logic                 beg_diag_r2l,
   output logic [COL_WIDTH-1:0] ram_addr,
   output logic [ROW_WIDTH-1:0] row,
   output logic [COL_WIDTH-1:0] col,
   output logic                 err_overrun,
   output logic                 de_out,
   output logic                 h_sync_out,
   output logic                 v_sync_out
);

   localparam logic [COL_WIDTH-1:0] COL_HALF  = COL_WIDTH'(HALF_IMG_WIDTH);
   localparam logic [COL_WIDTH-1:0] COL_LAST  = COL_WIDTH'(2 * HALF_IMG_WIDTH - 1);
   localparam logic [COL_WIDTH-1:0] ADDR_LAST = COL_WIDTH'(HALF_IMG_WIDTH + 1);
   localparam int                   DLY_W     = 3 * (PIPE_LATENCY + 1);

   typedef enum logic [1:0] {WAIT_FRAME, BLANK, LINE} state_t;

   state_t               state, state_nxt;
   logic                 de_prev, vs_prev;
   logic                 vs_rise, de_rise;
   logic                 pix, over;
   logic [COL_WIDTH-1:0] col_nxt;
   logic [ROW_WIDTH-1:0] row_nxt;
   logic                 half_nxt, top_nxt, bh_nxt, r2l_nxt;
   logic [7:0]           pend_p1, pend_p2;
   logic [DLY_W-1:0]     sync_dly;

   assign vs_rise = v_sync_in & ~vs_prev;
   assign de_rise = de_in & ~de_prev;

   always_comb begin
      state_nxt = state;
      pix       = 1'b0;
      over      = 1'b0;
      col_nxt   = col;
      row_nxt   = row;
      if (vs_rise) begin
         state_nxt = BLANK;
         row_nxt   = '0;
      end else begin
         case (state)
            WAIT_FRAME: ;
            BLANK: begin
               if (de_rise) begin
                  state_nxt = LINE;
                  pix       = 1'b1;
                  col_nxt   = '0;
               end
            end
            LINE: begin
               if (de_in) begin
                  pix = 1'b1;
                  if (col == COL_LAST) over = 1'b1;
                  else                 col_nxt = col + COL_WIDTH'(1);
               end else begin
                  state_nxt = BLANK;
                  if (row != '1) row_nxt = row + ROW_WIDTH'(1);
               end
            end
            default: state_nxt = WAIT_FRAME;
         endcase
      end
      // row is only updated at line end, so the registered row is this pixel's row
      half_nxt = pix & ~over & (col_nxt >= COL_HALF);
      bh_nxt   = half_nxt & (col_nxt == COL_HALF);
      top_nxt  = half_nxt & (row == '0);
      r2l_nxt  = (half_nxt & (col_nxt == COL_LAST)) | top_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= WAIT_FRAME;
         de_prev        <= 1'b0;
         vs_prev        <= 1'b0;
         col            <= '0;
         row            <= '0;
         half_de        <= 1'b0;
         ext_half_de    <= 1'b0;
         beg_horizontal <= 1'b0;
         beg_top        <= 1'b0;
         beg_diag_l2r   <= 1'b0;
         beg_diag_r2l   <= 1'b0;
         ram_addr       <= '0;
         err_overrun    <= 1'b0;
      end else begin
         state          <= state_nxt;
         de_prev        <= de_in;
         vs_prev        <= v_sync_in;
         col            <= col_nxt;
         row            <= row_nxt;
         half_de        <= half_nxt;
         ext_half_de    <= half_nxt | half_de;
         beg_horizontal <= bh_nxt;
         beg_top        <= top_nxt;
         beg_diag_l2r   <= bh_nxt | top_nxt;
         beg_diag_r2l   <= r2l_nxt;
         if (vs_rise)          ram_addr <= '0;
         else if (ext_half_de) ram_addr <= (ram_addr == ADDR_LAST) ? '0 : ram_addr + COL_WIDTH'(1);
         if (vs_rise)   err_overrun <= 1'b0;
         else if (over) err_overrun <= 1'b1;
      end
   end

   // A write taken while cfg_ready is high cannot coincide with an apply, so a
   // write landing on a frame start waits for the following one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready <= 1'b1;
         p1        <= 8'd15;
         p2        <= 8'd100;
         pend_p1   <= '0;
         pend_p2   <= '0;
      end else if (vs_rise && !cfg_ready) begin
         p1        <= pend_p1;
         p2        <= pend_p2;
         cfg_ready <= 1'b1;
      end else if (cfg_valid && cfg_ready) begin
         pend_p1   <= cfg_p1;
         pend_p2   <= cfg_p2;
         cfg_ready <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_dly <= '0;
      else        sync_dly <= DLY_W'({sync_dly, v_sync_in, h_sync_in, de_in});
   end

   assign {v_sync_out, h_sync_out, de_out} = sync_dly[DLY_W-1 -: 3];

endmodule

// File: tb/tb_sgm_frame_sequencer.sv
// Directed bench for sgm_frame_sequencer: a pixel-level reference model checked every
// cycle, plus literal expectations on per-line strobe counts and penalty behaviour.
module tb_sgm_frame_sequencer;

   localparam int HW   = 640;
   localparam int RW   = 10;
   localparam int CW   = 11;
   localparam int PL   = 1;
   localparam int LAST = 2 * HW - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [7:0]    cfg_p1 = '0, cfg_p2 = '0;
   logic          cfg_ready;
   logic [7:0]    p1, p2;
   logic          half_de, ext_half_de;
   logic          beg_horizontal, beg_top, beg_diag_l2r, beg_diag_r2l;
   logic [CW-1:0] ram_addr;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic          err_overrun;
   logic          de_out, h_sync_out, v_sync_out;

   sgm_frame_sequencer #(
      .HALF_IMG_WIDTH(HW),
      .ROW_WIDTH     (RW),
      .COL_WIDTH     (CW),
      .PIPE_LATENCY  (PL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .de_in         (de_in),
      .h_sync_in     (h_sync_in),
      .v_sync_in     (v_sync_in),
      .cfg_valid     (cfg_valid),
      .cfg_p1        (cfg_p1),
      .cfg_p2        (cfg_p2),
      .cfg_ready     (cfg_ready),
      .p1            (p1),
      .p2            (p2),
      .half_de       (half_de),
      .ext_half_de   (ext_half_de),
      .beg_horizontal(beg_horizontal),
      .beg_top       (beg_top),
      .beg_diag_l2r  (beg_diag_l2r),
      .beg_diag_r2l  (beg_diag_r2l),
      .ram_addr      (ram_addr),
      .row           (row),
      .col           (col),
      .err_overrun   (err_overrun),
      .de_out        (de_out),
      .h_sync_out    (h_sync_out),
      .v_sync_out    (v_sync_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pixels are numbered by their run position since the line's
   // de rise; only lines that start after a frame start are counted.
   bit m_armed, m_in_line, m_prev_de, m_prev_vs, m_pend;
   int m_run;
   int m_pp1, m_pp2;
   bit vs_r, de_r, de_f, pix, ovr, half_new;
   int e_row, e_col, e_ram, e_p1, e_p2;
   bit e_half, e_ext, e_bh, e_top, e_l2r, e_r2l, e_err, e_ready;
   bit h_de [PL+1], h_hs [PL+1], h_vs [PL+1];

   int cnt_half, cnt_ext, cnt_top, cnt_bh, cnt_r2l, bh_col, r2l_col;

   task automatic clr_cnt();
      cnt_half = 0; cnt_ext = 0; cnt_top = 0; cnt_bh = 0; cnt_r2l = 0;
      bh_col = -1; r2l_col = -1;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_armed = 0; m_in_line = 0; m_prev_de = 0; m_prev_vs = 0; m_pend = 0; m_run = 0;
         e_row = 0; e_col = 0; e_ram = 0; e_p1 = 15; e_p2 = 100; e_ready = 1;
         e_half = 0; e_ext = 0; e_bh = 0; e_top = 0; e_l2r = 0; e_r2l = 0; e_err = 0;
         for (int i = 0; i <= PL; i++) begin h_de[i] = 0; h_hs[i] = 0; h_vs[i] = 0; end
      end else begin
         vs_r = v_sync_in && !m_prev_vs;
         de_r = de_in && !m_prev_de;
         de_f = !de_in && m_prev_de;
         pix = 0; ovr = 0; half_new = 0;
         if (vs_r) begin
            m_armed = 1; m_in_line = 0; e_row = 0; e_err = 0;
         end else if (m_armed) begin
            if (de_r) begin
               m_in_line = 1; m_run = 0; pix = 1;
            end else if (de_in && m_in_line) begin
               m_run++; pix = 1;
            end else if (de_f && m_in_line) begin
               m_in_line = 0;
               if (e_row < (1 << RW) - 1) e_row++;
            end
         end
         if (pix) begin
            e_col    = (m_run > LAST) ? LAST : m_run;
            ovr      = m_run > LAST;
            half_new = !ovr && m_run >= HW;
            if (ovr) e_err = 1;
         end
         e_bh  = half_new && e_col == HW;
         e_top = half_new && e_row == 0;
         e_l2r = e_bh || e_top;
         e_r2l = (half_new && e_col == LAST) || e_top;
         if (vs_r)       e_ram = 0;
         else if (e_ext) e_ram = (e_ram + 1) % (HW + 2);
         e_ext  = half_new || e_half;
         e_half = half_new;
         if (vs_r && m_pend) begin
            e_p1 = m_pp1; e_p2 = m_pp2; m_pend = 0;
         end else if (cfg_valid && !m_pend) begin
            m_pp1 = cfg_p1; m_pp2 = cfg_p2; m_pend = 1;
         end
         e_ready = !m_pend;
         for (int i = PL; i > 0; i--) begin
            h_de[i] = h_de[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
         end
         h_de[0] = de_in; h_hs[0] = h_sync_in; h_vs[0] = v_sync_in;
         m_prev_de = de_in;
         m_prev_vs = v_sync_in;
      end
      #1;
      chk("half_de",        half_de,        e_half);
      chk("ext_half_de",    ext_half_de,    e_ext);
      chk("beg_horizontal", beg_horizontal, e_bh);
      chk("beg_top",        beg_top,        e_top);
      chk("beg_diag_l2r",   beg_diag_l2r,   e_l2r);
      chk("beg_diag_r2l",   beg_diag_r2l,   e_r2l);
      chk("ram_addr",       ram_addr,       e_ram);
      chk("row",            row,            e_row);
      chk("col",            col,            e_col);
      chk("err_overrun",    err_overrun,    e_err);
      chk("p1",             p1,             e_p1);
      chk("p2",             p2,             e_p2);
      chk("cfg_ready",      cfg_ready,      e_ready);
      chk("de_out",         de_out,         h_de[PL]);
      chk("h_sync_out",     h_sync_out,     h_hs[PL]);
      chk("v_sync_out",     v_sync_out,     h_vs[PL]);
      if (half_de)     cnt_half++;
      if (ext_half_de) cnt_ext++;
      if (beg_top)     cnt_top++;
      if (beg_horizontal) begin cnt_bh++; bh_col = int'(col); end
      if (beg_diag_r2l)   begin cnt_r2l++; r2l_col = int'(col); end
   end

   task automatic step(input logic de, input logic hs, input logic vs);
      de_in = de; h_sync_in = hs; v_sync_in = vs;
      @(negedge clk);
   endtask

   task automatic line(input int n_de, input int n_blank);
      for (int i = 0; i < n_de; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n_blank; i++) step(1'b0, (i < 4), 1'b0);
   endtask

   task automatic vsync();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   int got;

   initial begin
      clr_cnt();
      repeat (3) @(negedge clk);
      chk("reset_p1", p1, 15);
      chk("reset_p2", p2, 100);
      chk("reset_cfg_ready", cfg_ready, 1);
      chk("reset_ram_addr", ram_addr, 0);
      rst_n = 1'b1;

      // lines before the first frame start are ignored
      clr_cnt();
      line(1280, 20);
      chk("preframe_half_cnt", cnt_half, 0);
      chk("preframe_top_cnt", cnt_top, 0);
      chk("preframe_col", col, 0);
      chk("preframe_row", row, 0);

      // frame A, row 0
      vsync();
      clr_cnt();
      line(1280, 20);
      chk("row0_half_cnt", cnt_half, 640);
      chk("row0_top_cnt", cnt_top, 640);
      chk("row0_bh_cnt", cnt_bh, 1);
      chk("row0_bh_col", bh_col, 640);
      chk("row0_r2l_cnt", cnt_r2l, 640);
      chk("row0_r2l_last_col", r2l_col, 1279);
      chk("row0_ext_cnt", cnt_ext, 641);
      chk("row0_ram_addr", ram_addr, 641);

      // penalty write mid-frame, then a blocked second write
      cfg_valid = 1'b1; cfg_p1 = 8'd20; cfg_p2 = 8'd80;
      step(1'b0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      chk("wr1_cfg_ready", cfg_ready, 0);
      cfg_valid = 1'b1; cfg_p1 = 8'd5; cfg_p2 = 8'd6;
      step(1'b0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      chk("wr2_p1_unchanged", p1, 15);
      chk("wr2_p2_unchanged", p2, 100);

      // frame A, row 1
      clr_cnt();
      line(1280, 20);
      chk("row1_top_cnt", cnt_top, 0);
      chk("row1_bh_cnt", cnt_bh, 1);
      chk("row1_r2l_cnt", cnt_r2l, 1);
      chk("row1_r2l_col", r2l_col, 1279);
      chk("row1_ram_wrap", ram_addr, 640);
      chk("row_after_two", row, 2);
      chk("row1_p1_held", p1, 15);

      // frame B: penalties applied, overrun line
      vsync();
      chk("applied_p1", p1, 20);
      chk("applied_p2", p2, 80);
      chk("applied_ready", cfg_ready, 1);
      chk("fs_row", row, 0);
      chk("fs_ram_addr", ram_addr, 0);
      clr_cnt();
      line(1290, 20);
      chk("ovr_half_cnt", cnt_half, 640);
      chk("ovr_col", col, 1279);
      chk("ovr_err", err_overrun, 1);

      // write coinciding with frame start is deferred one frame
      cfg_valid = 1'b1; cfg_p1 = 8'd30; cfg_p2 = 8'd40;
      step(1'b0, 1'b0, 1'b1);
      cfg_valid = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      chk("ovr_err_cleared", err_overrun, 0);
      chk("fswr_p1_held", p1, 20);
      chk("fswr_ready", cfg_ready, 0);
      line(1280, 20);
      vsync();
      chk("fswr_p1_applied", p1, 30);
      chk("fswr_p2_applied", p2, 40);
      chk("fswr_ready_back", cfg_ready, 1);

      // reset mid-line at col 700
      for (int i = 0; i < 701; i++) step(1'b1, 1'b0, 1'b0);
      chk("pre_rst_col", col, 700);
      rst_n = 1'b0;
      #1;
      chk("rst_col", col, 0);
      chk("rst_half_de", half_de, 0);
      chk("rst_p1", p1, 15);
      chk("rst_cfg_ready", cfg_ready, 1);
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      line(577, 20);
      chk("post_rst_half_cnt", cnt_half, 0);
      chk("post_rst_ext_cnt", cnt_ext, 0);
      chk("post_rst_col", col, 0);

      // timing delay latency, both edges
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (de_out === 1'b1) begin got = i; break; end
      end
      chk("de_out_rise_latency", got, PL + 1);
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (de_out === 1'b0) begin got = i; break; end
      end
      chk("de_out_fall_latency", got, PL + 1);

      // normal operation after recovery
      vsync();
      clr_cnt();
      line(1280, 20);
      chk("recover_half_cnt", cnt_half, 640);
      chk("recover_top_cnt", cnt_top, 640);
      chk("recover_row", row, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
